mips_fetch_unit: RTL and testbench
==================================

// Module: mips_fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage for the MIPS core: owns the PC, computes
//  branch targets (PC+4+sext(imm)<<2), issues in-order requests to instruction
//  memory and buffers returned words in a DEPTH-entry prefetch FIFO. Instructions
//  go to decode over a valid/ready handshake. Sits between imem and registerFile/decode.
// PARAMETERS
//  ADDR_W    32  PC / imem address width
//  DATA_W    32  instruction word width
//  DEPTH     4   prefetch FIFO entries; power of 2, >=2
//  RESET_PC  0   PC loaded on reset
// PORTS
//  clk              in   1                    clock, rising edge
//  rstn             in   1                    async active-low reset
//  imem_req_valid   out  1                    fetch request valid
//  imem_req_ready   in   1                    imem accepts request
//  imem_req_addr    out  ADDR_W               fetch address (word aligned)
//  imem_rsp_valid   in   1                    response valid, in request order, latency >=1
//  imem_rsp_data    in   DATA_W               returned instruction
//  br_valid         in   1                    redirect strobe (1 cycle)
//  br_pc            in   ADDR_W               PC of the branch instruction
//  br_imm           in   16                   branch immediate
//  out_valid        out  1                    instruction available to decode
//  out_ready        in   1                    decode accepts
//  out_instr        out  DATA_W               instruction word
//  out_pc           out  ADDR_W               PC of out_instr
//  occupancy        out  $clog2(DEPTH+1)      FIFO entries held
// BEHAVIOUR
//  Reset (async, any cycle): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty,
//   outstanding=0, drop_cnt=0, state=FETCH; out_valid=0, out_instr=0, out_pc=0,
//   occupancy=0, imem_req_valid=0, imem_req_addr=RESET_PC. imem shares rstn.
//  Credit: imem_req_valid = (occupancy+outstanding < DEPTH), from registers only,
//   so first request is in the first clock after rstn release. imem_req_addr=fetch_pc.
//  Request handshake (valid&&ready): fetch_pc+=4, outstanding+=1. Addr/valid held
//   stable while ready=0 (unless redirect).
//  Response: outstanding-=1. drop_cnt>0 -> discard, drop_cnt-=1; else push
//   {rsp_pc,data} to FIFO, rsp_pc+=4. Credit guarantees FIFO never overflows.
//  Output: head registered; response pushed in cycle N visible at out_valid in N+1.
//   Pop on out_valid&&out_ready. Empty -> out_valid=0, out_instr/out_pc hold last.
//  Redirect (br_valid): target = br_pc + 4 + ({{(ADDR_W-18){imm[15]}},imm,2'b00}),
//   mod 2^ADDR_W, low 2 bits forced 0. Next cycle: fetch_pc=rsp_pc=target, FIFO
//   flushed (occupancy=0, out_valid=0), drop_cnt = outstanding after this cycle's
//   req/rsp updates (request accepted this cycle counts as stale; response this
//   cycle is discarded).
//  FSM: FETCH -> DRAIN on redirect with drop_cnt>0; DRAIN -> FETCH when drop_cnt
//   reaches 0; redirect in DRAIN reloads drop_cnt, stays DRAIN. Requests to the new
//   target may issue during DRAIN (stale responses counted in credit).
//  Simultaneous: out handshake + redirect same cycle -> that instruction is
//   delivered, rest flushed. Push + pop same cycle -> occupancy unchanged.
//  Wrap: fetch_pc/rsp_pc wrap mod 2^ADDR_W; FIFO pointers wrap mod DEPTH.
// TESTING
//  1 rstn release, imem lat=1, ready=1, out_ready=1 -> out_pc 0,4,8,.. with matching
//    data; first out_valid 3 cycles after release; no gaps in steady state.
//  2 out_ready=0 for 20 cycles, DEPTH=4 -> occupancy stops at 4, req_valid=0,
//    exactly 4 requests issued; release -> order preserved, no loss/dup.
//  3 br_valid, br_pc=0x10, br_imm=0xFFFC -> next req_addr=0x04, next out_pc=0x04.
//  4 imem lat=3, redirect with 3 in flight -> 3 responses dropped, DRAIN seen,
//    first out_pc=target, no stale word reaches decode.
//  5 req_ready=0 for 5 cycles -> req_addr/valid stable; redirect mid-stall changes
//    addr next cycle to target.
//  6 rstn low mid-stream with full FIFO -> outputs at reset values immediately;
//    restart fetches from RESET_PC; fetch_pc=0xFFFFFFFC wraps to 0x0.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: PC ownership, branch redirect, credit-limited
// in-order imem requests and a prefetch FIFO with a registered head to decode.
module mips_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [ADDR_W-1:0]          imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [DATA_W-1:0]          imem_rsp_data,
  input  logic                       br_valid,
  input  logic [ADDR_W-1:0]          br_pc,
  input  logic [15:0]                br_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  fetch_pc, fetch_pc_n;
  logic [ADDR_W-1:0]  rsp_pc, rsp_pc_n;
  logic [CNT_W-1:0]   outstanding, outst_n;
  logic [CNT_W-1:0]   drop_cnt, drop_n;
  logic [CNT_W-1:0]   occ_n, remain;
  logic [PTR_W-1:0]   wptr, wptr_n, rptr, rptr_n;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [ENT_W-1:0]   head;
  logic [ADDR_W-1:0]  br_offset, br_sum, target;
  logic               req_fire, pop, push, rsp_drop, credit_ok;

  // Next-state computation for PCs, counters, FIFO pointers and redirect
  always_comb begin
    req_fire  = imem_req_valid & imem_req_ready;
    pop       = out_valid & out_ready;
    push      = imem_rsp_valid & (drop_cnt == '0) & ~br_valid;
    rsp_drop  = imem_rsp_valid & (drop_cnt != '0);
    br_offset = {{(ADDR_W-18){br_imm[15]}}, br_imm, 2'b00};
    br_sum    = br_pc + PC_STEP + br_offset;
    target    = {br_sum[ADDR_W-1:2], 2'b00};
    outst_n   = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    remain    = occupancy - CNT_W'(pop);
    wptr_n    = wptr + PTR_W'(push);
    rptr_n    = rptr + PTR_W'(pop);
    occ_n      = remain + CNT_W'(push);
    fetch_pc_n = req_fire ? fetch_pc + PC_STEP : fetch_pc;
    rsp_pc_n   = push ? rsp_pc + PC_STEP : rsp_pc;
    drop_n     = drop_cnt - CNT_W'(rsp_drop);
    state_n    = (state == DRAIN && drop_n == '0) ? FETCH : state;
    // Redirect: everything in flight right now becomes stale and is counted off
    if (br_valid) begin
      occ_n      = '0;
      rptr_n     = wptr;
      fetch_pc_n = target;
      rsp_pc_n   = target;
      drop_n     = outst_n;
      state_n    = (outst_n != '0) ? DRAIN : FETCH;
    end
    // Head comes straight from the response when nothing older remains
    head      = (remain == '0) ? {rsp_pc, imem_rsp_data} : mem[rptr_n];
    credit_ok = ({1'b0, occ_n} + {1'b0, outst_n}) < (CNT_W+1)'(DEPTH);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= FETCH;
      fetch_pc       <= RESET_PC;
      rsp_pc         <= RESET_PC;
      outstanding    <= '0;
      drop_cnt       <= '0;
      wptr           <= '0;
      rptr           <= '0;
      occupancy      <= '0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= RESET_PC;
      out_valid      <= 1'b0;
      out_instr      <= '0;
      out_pc         <= '0;
    end else begin
      state          <= state_n;
      fetch_pc       <= fetch_pc_n;
      rsp_pc         <= rsp_pc_n;
      outstanding    <= outst_n;
      drop_cnt       <= drop_n;
      wptr           <= wptr_n;
      rptr           <= rptr_n;
      occupancy      <= occ_n;
      imem_req_valid <= credit_ok;
      imem_req_addr  <= fetch_pc_n;
      out_valid      <= (occ_n != '0);
      if (occ_n != '0) {out_pc, out_instr} <= head;
    end
  end

  // FIFO storage; contents are only meaningful below occupancy
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {rsp_pc, imem_rsp_data};
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: imem latency model plus an
// expected-stream scoreboard restarted on every reset and redirect.
module tb_mips_fetch_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rstn;
  logic              imem_req_valid, imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              br_valid;
  logic [ADDR_W-1:0] br_pc;
  logic [15:0]       br_imm;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [OCC_W-1:0]  occupancy;

  mips_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rstn(rstn),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .br_valid(br_valid), .br_pc(br_pc), .br_imm(br_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] imm);
    logic [31:0] off;
    off = {{14{imm[15]}}, imm, 2'b00};
    return (pc + 32'd4 + off) & 32'hFFFF_FFFC;
  endfunction

  // In-order instruction memory with programmable latency
  typedef struct packed {logic [31:0] addr; logic [31:0] due;} mreq_t;
  mreq_t       mq[$];
  logic [31:0] cyc = '0;
  int unsigned lat = 1;

  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready)
        mq.push_back('{addr: imem_req_addr, due: cyc + 32'(lat) - 32'd1});
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  int n_req = 0;
  always @(posedge clk) if (rstn && imem_req_valid && imem_req_ready) n_req <= n_req + 1;

  // Scoreboard of the instruction stream decode must see
  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} exp_t;
  exp_t sb[$];

  task automatic sb_restart(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 128; i++)
      sb.push_back('{pc: start + 32'(4 * i), instr: mem_word(start + 32'(4 * i))});
  endtask

  int          n_pop = 0;
  logic        drop_pend = 1'b0;
  logic [31:0] drop_exp = '0;
  exp_t        e;

  always @(negedge clk) begin
    if (!rstn) begin
      drop_pend <= 1'b0;
    end else begin
      if (drop_pend) begin
        check("drop_cnt_model", 64'(dut.drop_cnt), 64'(drop_exp));
        check("drain_state_model", 64'(dut.state), 64'(drop_exp != 0));
        drop_pend <= 1'b0;
      end
      if (out_valid && out_ready) begin
        n_pop <= n_pop + 1;
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("out_pc", 64'(out_pc), 64'(e.pc));
          check("out_instr", 64'(out_instr), 64'(e.instr));
        end
      end
      if (br_valid) begin
        sb_restart(br_target(br_pc, br_imm));
        drop_exp  <= 32'(mq.size()) + 32'(imem_req_valid && imem_req_ready);
        drop_pend <= 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_out_valid"}, 64'(out_valid), 64'(0));
    check({pfx, "_out_instr"}, 64'(out_instr), 64'(0));
    check({pfx, "_out_pc"}, 64'(out_pc), 64'(0));
    check({pfx, "_occupancy"}, 64'(occupancy), 64'(0));
    check({pfx, "_req_valid"}, 64'(imem_req_valid), 64'(0));
    check({pfx, "_req_addr"}, 64'(imem_req_addr), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int          first_seen, gaps, snap, p0, found;
  logic [31:0] a0;

  initial begin
    rstn = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1;
    br_valid = 1'b0; br_pc = '0; br_imm = '0;
    sb_restart(32'h0);
    tick(3);
    check_reset_outputs("rst");

    // Start-up latency and gap-free streaming
    rstn = 1'b1;
    tick(1);
    check("first_req_valid", 64'(imem_req_valid), 64'(1));
    check("first_req_addr", 64'(imem_req_addr), 64'(0));
    first_seen = 0;
    for (int i = 2; i <= 10 && first_seen == 0; i++) begin
      tick(1);
      if (out_valid) first_seen = i;
    end
    check("first_out_valid_cycle", 64'(first_seen), 64'(3));
    gaps = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (!out_valid) gaps++;
    end
    check("steady_gaps", 64'(gaps), 64'(0));

    // Backpressure from decode fills the FIFO and stops requests
    rstn = 1'b0; out_ready = 1'b0;
    sb_restart(32'h0);
    tick(2);
    rstn = 1'b1;
    snap = n_req;
    tick(20);
    check("stall_occupancy", 64'(occupancy), 64'(4));
    check("stall_req_valid", 64'(imem_req_valid), 64'(0));
    check("stall_req_count", 64'(n_req - snap), 64'(4));
    p0 = n_pop;
    out_ready = 1'b1;
    tick(12);
    check("stall_release_flow", 64'((n_pop - p0) >= 10), 64'(1));

    // Backward branch: 0x10 + 4 - 16 = 0x4
    br_valid = 1'b1; br_pc = 32'h10; br_imm = 16'hFFFC;
    tick(1);
    br_valid = 1'b0;
    check("br_req_addr", 64'(imem_req_addr), 64'h4);
    check("br_flush_occ", 64'(occupancy), 64'(0));
    check("br_flush_valid", 64'(out_valid), 64'(0));
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      tick(1);
      if (out_valid) found = 1;
    end
    check("br_first_out_seen", 64'(found), 64'(1));
    check("br_first_out_pc", 64'(out_pc), 64'h4);
    tick(10);

    // Long-latency memory: redirect with three requests in flight
    lat = 3;
    tick(20);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (32'(mq.size()) + 32'(imem_req_valid && imem_req_ready) == 32'd3) found = 1;
      else tick(1);
    end
    check("t4_three_inflight", 64'(found), 64'(1));
    br_valid = 1'b1; br_pc = 32'h200; br_imm = 16'h0008;
    tick(1);
    br_valid = 1'b0;
    check("t4_drop_cnt", 64'(dut.drop_cnt), 64'(3));
    check("t4_drain", 64'(dut.state), 64'(1));
    found = 0;
    for (int i = 0; i < 15 && found == 0; i++) begin
      tick(1);
      if (out_valid) found = 1;
    end
    check("t4_first_out_seen", 64'(found), 64'(1));
    check("t4_drain_done", 64'(dut.state), 64'(0));
    check("t4_first_out_pc", 64'(out_pc), 64'h224);
    tick(15);
    lat = 1;
    tick(10);

    // Request stall holds address/valid; a redirect still retargets
    imem_req_ready = 1'b0;
    tick(1);
    a0 = imem_req_addr;
    check("t5_valid_held", 64'(imem_req_valid), 64'(1));
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("t5_addr_stable", 64'(imem_req_addr), 64'(a0));
      check("t5_valid_stable", 64'(imem_req_valid), 64'(1));
    end
    br_valid = 1'b1; br_pc = 32'h100; br_imm = 16'h0010;
    tick(1);
    br_valid = 1'b0;
    check("t5_br_addr", 64'(imem_req_addr), 64'h144);
    tick(2);
    check("t5_br_addr_held", 64'(imem_req_addr), 64'h144);
    imem_req_ready = 1'b1;
    tick(15);

    // Reset with a full FIFO, then PC wrap at the top of the address space
    out_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1);
      if (occupancy == OCC_W'(4)) found = 1;
    end
    check("t6_full_before_reset", 64'(found), 64'(1));
    rstn = 1'b0;
    sb_restart(32'h0);
    #1;
    check_reset_outputs("midrst");
    tick(2);
    rstn = 1'b1; out_ready = 1'b1;
    tick(12);
    br_valid = 1'b1; br_pc = 32'hFFFF_FFF8; br_imm = 16'h0000;
    tick(1);
    br_valid = 1'b0;
    check("wrap_req_addr", 64'(imem_req_addr), 64'hFFFF_FFFC);
    tick(1);
    check("wrap_req_addr_next", 64'(imem_req_addr), 64'h0);
    tick(12);
    check("total_delivered", 64'(n_pop >= 60), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
